// File: rtl/mac_dot_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mac_dot_sched
//  Brief    : Job sequencer wrapping a streaming mac into a dot-product engine.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_dot_sched #(
    parameter int int_in_p       = 2,
    parameter int frac_in_p      = 14,
    parameter int int_out_p      = 10,
    parameter int frac_out_p     = 22,
    parameter int len_width_p    = 8,
    parameter int clear_cycles_p = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            cmd_valid_i,
    input  logic [len_width_p-1:0]          cmd_len_i,
    output logic                            cmd_ready_o,
    input  logic [int_in_p+frac_in_p-1:0]   a_i,
    input  logic [int_in_p+frac_in_p-1:0]   b_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic [int_out_p+frac_out_p-1:0] result_o,
    output logic                            result_valid_o,
    input  logic                            result_ready_i,
    output logic                            busy_o,
    output logic                            err_o,
    output logic                            mac_reset_o,
    output logic [int_in_p+frac_in_p-1:0]   mac_a_o,
    output logic [int_in_p+frac_in_p-1:0]   mac_b_o,
    output logic                            mac_valid_o,
    input  logic                            mac_ready_i,
    input  logic [int_out_p+frac_out_p-1:0] mac_data_i,
    input  logic                            mac_valid_i,
    output logic                            mac_ready_o
);

    localparam int c_clr_w = (clear_cycles_p > 1) ? $clog2(clear_cycles_p) : 1;
    localparam logic [c_clr_w-1:0] c_clr_last = c_clr_w'(clear_cycles_p - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [len_width_p-1:0]          r_len;
    logic [len_width_p-1:0]          r_issued;
    logic [len_width_p-1:0]          r_returned;
    logic [c_clr_w-1:0]              r_clr_cnt;
    logic [int_out_p+frac_out_p-1:0] r_result;
    logic                            r_err;

    logic w_in_feed;
    logic w_out_side;
    logic w_cmd_fire;
    logic w_issue;
    logic w_ret;
    logic w_last_issue;
    logic w_last_ret;

    assign w_in_feed    = (r_state == S_FEED);
    assign w_out_side   = (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_cmd_fire   = cmd_valid_i && cmd_ready_o;
    assign w_issue      = valid_i && ready_o;
    assign w_ret        = mac_valid_i && mac_ready_o;
    assign w_last_issue = w_issue && (r_issued == r_len - 1'b1);
    assign w_last_ret   = w_ret && (r_returned == r_len - 1'b1);

    // Handshake outputs are gated by reset so nothing can fire while it is asserted
    assign cmd_ready_o    = reset_ni && (r_state == S_IDLE);
    assign ready_o        = reset_ni && w_in_feed && mac_ready_i;
    assign mac_valid_o    = reset_ni && w_in_feed && valid_i;
    assign mac_ready_o    = reset_ni && w_out_side;
    assign mac_reset_o    = !reset_ni || (r_state == S_CLEAR);
    assign mac_a_o        = a_i;
    assign mac_b_o        = b_i;
    assign result_o       = r_result;
    assign result_valid_o = (r_state == S_RESULT);
    assign busy_o         = (r_state != S_IDLE);
    assign err_o          = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    w_next = (cmd_len_i == '0) ? S_RESULT : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == c_clr_last) w_next = S_FEED;
            end
            S_FEED: begin
                // Final return wins even when it lands on the last issue
                if (w_last_ret)        w_next = S_RESULT;
                else if (w_last_issue) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last_ret) w_next = S_RESULT;
            end
            S_RESULT: begin
                if (result_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_returned <= '0;
            r_clr_cnt  <= '0;
            r_result   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + c_clr_w'(1);
            else                    r_clr_cnt <= '0;
            if (w_cmd_fire) begin
                r_len      <= cmd_len_i;
                r_issued   <= '0;
                r_returned <= '0;
                if (cmd_len_i == '0) r_result <= '0;
            end
            if (w_issue) r_issued <= r_issued + 1'b1;
            if (w_ret) begin
                r_returned <= r_returned + 1'b1;
                r_result   <= mac_data_i;
            end
            if (mac_valid_i && (!w_out_side || (r_returned == r_issued))) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
